// File: rtl/alu_arbiter_if.sv
// One requester's request/response channel pair into the ALU arbiter.
// The arbiter takes the slave side; the requester (or bench) drives the master side.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_pos;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_pos
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_pos
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and the
// branch/PC unit (port 1); operands are held for ALU_LATENCY cycles before capture.
module alu_arbiter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_arbiter_if.slave     req0,
    alu_arbiter_if.slave     req1,
    output logic [3:0]       alu_inst_id,
    output logic [WIDTH-1:0] alu_in0,
    output logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_pos,
    output logic             busy,
    output logic             grant
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] LatInit = 4'(ALU_LATENCY);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] in0_q, in0_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
    logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
    logic             rsp0_zero_q, rsp0_zero_d;
    logic             rsp1_zero_q, rsp1_zero_d;
    logic             rsp0_pos_q, rsp0_pos_d;
    logic             rsp1_pos_q, rsp1_pos_d;

    logic sel;
    logic take;
    logic rsp_done;

    // On a tie the port that did not win last time goes next.
    assign sel  = (req0.req_valid && req1.req_valid) ? ~grant_q : req1.req_valid;
    assign take = (state_q == StIdle) && (req0.req_valid || req1.req_valid) && !reset;

    assign req0.req_ready = take && !sel;
    assign req1.req_ready = take && sel;

    assign rsp_done = grant_q ? (rsp1_valid_q && req1.rsp_ready)
                              : (rsp0_valid_q && req0.rsp_ready);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        op_d          = op_q;
        in0_d         = in0_q;
        in1_d         = in1_q;
        rsp0_valid_d  = rsp0_valid_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp1_result_d = rsp1_result_q;
        rsp0_zero_d   = rsp0_zero_q;
        rsp1_zero_d   = rsp1_zero_q;
        rsp0_pos_d    = rsp0_pos_q;
        rsp1_pos_d    = rsp1_pos_q;

        unique case (state_q)
            StIdle: begin
                if (take) begin
                    op_d    = sel ? req1.req_op : req0.req_op;
                    in0_d   = sel ? req1.req_a : req0.req_a;
                    in1_d   = sel ? req1.req_b : req0.req_b;
                    grant_d = sel;
                    cnt_d   = LatInit;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q <= 4'd1) begin
                    if (grant_q) begin
                        rsp1_valid_d  = 1'b1;
                        rsp1_result_d = alu_out;
                        rsp1_zero_d   = alu_zero;
                        rsp1_pos_d    = alu_pos;
                    end else begin
                        rsp0_valid_d  = 1'b1;
                        rsp0_result_d = alu_out;
                        rsp0_zero_d   = alu_zero;
                        rsp0_pos_d    = alu_pos;
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_done) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            grant_q       <= 1'b1;
            op_q          <= 4'd0;
            in0_q         <= '0;
            in1_q         <= '0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp1_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_zero_q   <= 1'b0;
            rsp0_pos_q    <= 1'b0;
            rsp1_pos_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            op_q          <= op_d;
            in0_q         <= in0_d;
            in1_q         <= in1_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp1_result_q <= rsp1_result_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_zero_q   <= rsp1_zero_d;
            rsp0_pos_q    <= rsp0_pos_d;
            rsp1_pos_q    <= rsp1_pos_d;
        end
    end

    assign alu_inst_id     = op_q;
    assign alu_in0         = in0_q;
    assign alu_in1         = in1_q;
    assign busy            = (state_q != StIdle);
    assign grant           = grant_q;
    assign req0.rsp_valid  = rsp0_valid_q;
    assign req0.rsp_result = rsp0_result_q;
    assign req0.rsp_zero   = rsp0_zero_q;
    assign req0.rsp_pos    = rsp0_pos_q;
    assign req1.rsp_valid  = rsp1_valid_q;
    assign req1.rsp_result = rsp1_result_q;
    assign req1.rsp_zero   = rsp1_zero_q;
    assign req1.rsp_pos    = rsp1_pos_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a latency-1 instance with a behavioural ALU and a latency-4
// instance whose ALU outputs are driven directly by the bench.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(16)) p0 ();
    alu_arbiter_if #(.WIDTH(16)) p1 ();
    alu_arbiter_if #(.WIDTH(16)) q0 ();
    alu_arbiter_if #(.WIDTH(16)) q1 ();

    logic [3:0]  a_inst, b_inst;
    logic [15:0] a_in0, a_in1, b_in0, b_in1;
    logic [15:0] a_alu_out, b_alu_out;
    logic        a_alu_zero, a_alu_pos, b_alu_zero, b_alu_pos;
    logic        a_busy, a_grant, b_busy, b_grant;

    int n_chk = 0;
    int n_fail = 0;

    // Returns {zero, pos, result} of the ALU for a given opcode.
    function automatic logic [17:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [15:0] r;
        case (op)
            4'd0, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: r = a + b;
            4'd1, 4'd2, 4'd3, 4'd5, 4'd12:              r = a - b;
            default:                                     r = 16'd0;
        endcase
        return {(r == 16'd0), (!r[15] && r != 16'd0), r};
    endfunction

    assign {a_alu_zero, a_alu_pos, a_alu_out} = alu_ref(a_inst, a_in0, a_in1);

    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(1)) u_dut (
        .clk(clk), .reset(reset), .req0(p0), .req1(p1),
        .alu_inst_id(a_inst), .alu_in0(a_in0), .alu_in1(a_in1),
        .alu_out(a_alu_out), .alu_zero(a_alu_zero), .alu_pos(a_alu_pos),
        .busy(a_busy), .grant(a_grant)
    );

    alu_arbiter #(.WIDTH(16), .ALU_LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .req0(q0), .req1(q1),
        .alu_inst_id(b_inst), .alu_in0(b_in0), .alu_in1(b_in1),
        .alu_out(b_alu_out), .alu_zero(b_alu_zero), .alu_pos(b_alu_pos),
        .busy(b_busy), .grant(b_grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        p0.req_valid = 1'b1;
        p1.req_valid = 1'b1;
        #1;
        n_chk++;
        if (p0.req_ready !== 1'b0 || p1.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready0/1=%b%b want 00", p0.req_ready, p1.req_ready);
        end
        n_chk++;
        if (a_busy !== 1'b0 || a_grant !== 1'b1 || b_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy_grant: busy=%b grant=%b grant4=%b want 0 1 1",
                     a_busy, a_grant, b_grant);
        end
        n_chk++;
        if (a_inst !== 4'd0 || a_in0 !== 16'd0 || a_in1 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_alu: inst=%h in0=%h in1=%h want 0 0 0", a_inst, a_in0, a_in1);
        end
        n_chk++;
        if ({p0.rsp_valid, p1.rsp_valid, p0.rsp_zero, p0.rsp_pos, p1.rsp_zero, p1.rsp_pos}
                !== 6'd0 || p0.rsp_result !== 16'd0 || p1.rsp_result !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: v0=%b v1=%b r0=%h r1=%h want all zero",
                     p0.rsp_valid, p1.rsp_valid, p0.rsp_result, p1.rsp_result);
        end
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_add();
        tick();
        p0.req_valid = 1'b1; p0.req_op = 4'b0000; p0.req_a = 16'd1; p0.req_b = 16'd1;
        #1;
        n_chk++;
        if (p0.req_ready !== 1'b1 || p1.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ready: ready0/1=%b%b want 10", p0.req_ready, p1.req_ready);
        end
        tick();
        p0.req_valid = 1'b0;
        #1;
        n_chk++;
        if (a_in0 !== 16'd1 || a_in1 !== 16'd1 || a_inst !== 4'd0 || a_busy !== 1'b1
                || p0.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_exec: in0=%h in1=%h busy=%b v0=%b want 1 1 1 0",
                     a_in0, a_in1, a_busy, p0.rsp_valid);
        end
        tick();
        n_chk++;
        if (p0.rsp_valid !== 1'b1 || p0.rsp_result !== 16'h0002 || p0.rsp_zero !== 1'b0
                || p0.rsp_pos !== 1'b1 || p1.rsp_valid !== 1'b0 || a_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL add_rsp: v0=%b r=%h z=%b p=%b v1=%b g=%b want 1 0002 0 1 0 0",
                     p0.rsp_valid, p0.rsp_result, p0.rsp_zero, p0.rsp_pos, p1.rsp_valid,
                     a_grant);
        end
    endtask

    task automatic run_op(input int port, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, output bit ok, output logic [15:0] res,
                          output logic z, output logic pz, output int lat);
        int n;
        tick();
        if (port == 0) begin
            p0.req_valid = 1'b1; p0.req_op = op; p0.req_a = a; p0.req_b = b;
        end else begin
            p1.req_valid = 1'b1; p1.req_op = op; p1.req_a = a; p1.req_b = b;
        end
        #1;
        n = 0;
        while (((port == 0) ? p0.req_ready : p1.req_ready) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        ok = (n < 20);
        tick();
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b0;
        lat = 1;
        while (((port == 0) ? p0.rsp_valid : p1.rsp_valid) !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        ok  = ok && (lat < 20);
        res = (port == 0) ? p0.rsp_result : p1.rsp_result;
        z   = (port == 0) ? p0.rsp_zero : p1.rsp_zero;
        pz  = (port == 0) ? p0.rsp_pos : p1.rsp_pos;
    endtask

    task automatic test_sub();
        bit ok;
        logic [15:0] res;
        logic z, pz;
        int lat;
        run_op(1, 4'b0001, 16'd1, 16'd1, ok, res, z, pz, lat);
        n_chk++;
        if (!ok || res !== 16'h0000 || z !== 1'b1 || pz !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL sub_zero: ok=%0d r=%h z=%b p=%b lat=%0d want 1 0000 1 0 2",
                     ok, res, z, pz, lat);
        end
        run_op(1, 4'b0001, 16'd1, 16'd2, ok, res, z, pz, lat);
        n_chk++;
        if (!ok || res !== 16'hFFFF || z !== 1'b0 || pz !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL sub_neg: ok=%0d r=%h z=%b p=%b lat=%0d want 1 ffff 0 0 2",
                     ok, res, z, pz, lat);
        end
    endtask

    task automatic test_alternate();
        int acc_t[$];
        int acc_p[$];
        int nrsp;
        nrsp = 0;
        tick();
        p0.req_valid = 1'b1; p0.req_op = 4'b0100; p0.req_a = 16'd1; p0.req_b = 16'd1;
        p1.req_valid = 1'b1; p1.req_op = 4'b1100; p1.req_a = 16'd5; p1.req_b = 16'd2;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (acc_p.size() < 4 && p0.req_ready === 1'b1) begin
                acc_p.push_back(0); acc_t.push_back(cyc);
            end
            if (acc_p.size() < 4 && p1.req_ready === 1'b1) begin
                acc_p.push_back(1); acc_t.push_back(cyc);
            end
            if (p0.rsp_valid === 1'b1) begin
                nrsp++;
                n_chk++;
                if (p0.rsp_result !== 16'h0002) begin
                    n_fail++;
                    $display("FAIL alt_rsp0: r=%h want 0002", p0.rsp_result);
                end
            end
            if (p1.rsp_valid === 1'b1) begin
                nrsp++;
                n_chk++;
                if (p1.rsp_result !== 16'h0003) begin
                    n_fail++;
                    $display("FAIL alt_rsp1: r=%h want 0003", p1.rsp_result);
                end
            end
            tick();
            if (acc_p.size() >= 4) begin
                p0.req_valid = 1'b0;
                p1.req_valid = 1'b0;
            end
            if (nrsp >= 4) break;
        end
        n_chk++;
        if (acc_p.size() != 4 || nrsp != 4) begin
            n_fail++;
            $display("FAIL alt_count: accepts=%0d rsps=%0d want 4 4", acc_p.size(), nrsp);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if (acc_p[i] != (i % 2)) begin
                    n_fail++;
                    $display("FAIL alt_order: accept %0d port=%0d want %0d", i, acc_p[i], i % 2);
                end
                if (i > 0) begin
                    n_chk++;
                    if (acc_t[i] - acc_t[i-1] != 3) begin
                        n_fail++;
                        $display("FAIL alt_gap: accept %0d gap=%0d want 3", i,
                                 acc_t[i] - acc_t[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        tick();
        p0.req_valid = 1'b1; p0.req_op = 4'b0000; p0.req_a = 16'd1; p0.req_b = 16'd1;
        p0.rsp_ready = 1'b0;
        #1;
        n_chk++;
        if (p0.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: ready0=%b want 1", p0.req_ready);
        end
        tick();
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b1; p1.req_op = 4'b0001; p1.req_a = 16'd3; p1.req_b = 16'd1;
        #1;
        n_chk++;
        if (p1.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_exec_ready1: ready1=%b want 0", p1.req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (p0.rsp_valid !== 1'b1 || p0.rsp_result !== 16'h0002 || a_busy !== 1'b1
                    || p1.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cyc=%0d v0=%b r=%h busy=%b ready1=%b want 1 0002 1 0",
                         i, p0.rsp_valid, p0.rsp_result, a_busy, p1.req_ready);
            end
        end
        tick();
        p0.rsp_ready = 1'b1;
        #1;
        n_chk++;
        if (p1.req_ready !== 1'b0 || p0.rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: ready1=%b v0=%b want 0 1", p1.req_ready, p0.rsp_valid);
        end
        tick();
        n_chk++;
        if (p1.req_ready !== 1'b1 || a_busy !== 1'b0 || p0.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next: ready1=%b busy=%b v0=%b want 1 0 0",
                     p1.req_ready, a_busy, p0.rsp_valid);
        end
        tick();
        p1.req_valid = 1'b0;
        tick();
        n_chk++;
        if (p1.rsp_valid !== 1'b1 || p1.rsp_result !== 16'h0002 || p1.rsp_pos !== 1'b1
                || p0.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_rsp1: v1=%b r=%h p=%b v0=%b want 1 0002 1 0",
                     p1.rsp_valid, p1.rsp_result, p1.rsp_pos, p0.rsp_valid);
        end
    endtask

    task automatic test_latency4();
        tick();
        b_alu_out = 16'h1111; b_alu_zero = 1'b1; b_alu_pos = 1'b0;
        q0.req_valid = 1'b1; q0.req_op = 4'b1000; q0.req_a = 16'd7; q0.req_b = 16'd9;
        #1;
        n_chk++;
        if (q0.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat4_accept: ready0=%b want 1", q0.req_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) q0.req_valid = 1'b0;
            if (k == 2) b_alu_out = 16'h2222;
            if (k == 3) b_alu_out = 16'h3333;
            if (k == 4) begin
                b_alu_out = 16'h4444; b_alu_zero = 1'b0; b_alu_pos = 1'b1;
            end
            #1;
            n_chk++;
            if (b_inst !== 4'b1000 || b_in0 !== 16'd7 || b_in1 !== 16'd9
                    || q0.rsp_valid !== 1'b0 || b_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL lat4_hold: T+%0d inst=%h in0=%h in1=%h v=%b busy=%b", k,
                         b_inst, b_in0, b_in1, q0.rsp_valid, b_busy);
            end
        end
        tick();
        n_chk++;
        if (q0.rsp_valid !== 1'b1 || q0.rsp_result !== 16'h4444 || q0.rsp_zero !== 1'b0
                || q0.rsp_pos !== 1'b1 || q1.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat4_rsp: v=%b r=%h z=%b p=%b want 1 4444 0 1",
                     q0.rsp_valid, q0.rsp_result, q0.rsp_zero, q0.rsp_pos);
        end
    endtask

    task automatic test_reset_exec();
        tick();
        p0.req_valid = 1'b1; p0.req_op = 4'b0000; p0.req_a = 16'd3; p0.req_b = 16'd4;
        #1;
        tick();
        p0.req_valid = 1'b0;
        #1;
        n_chk++;
        if (a_busy !== 1'b1 || a_in0 !== 16'd3) begin
            n_fail++;
            $display("FAIL rexec_pre: busy=%b in0=%h want 1 0003", a_busy, a_in0);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (a_busy !== 1'b0 || a_grant !== 1'b1 || a_inst !== 4'd0 || a_in0 !== 16'd0
                || a_in1 !== 16'd0 || p0.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rexec_async: busy=%b grant=%b in0=%h in1=%h v0=%b want 0 1 0 0 0",
                     a_busy, a_grant, a_in0, a_in1, p0.rsp_valid);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (p0.rsp_valid !== 1'b0 || p1.rsp_valid !== 1'b0 || a_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rexec_no_rsp: v0=%b v1=%b busy=%b want 0 0 0",
                         p0.rsp_valid, p1.rsp_valid, a_busy);
            end
        end
        p0.req_valid = 1'b1; p0.req_op = 4'b0000; p0.req_a = 16'd3; p0.req_b = 16'd4;
        p1.req_valid = 1'b1; p1.req_op = 4'b0001; p1.req_a = 16'd9; p1.req_b = 16'd1;
        #1;
        n_chk++;
        if (p0.req_ready !== 1'b1 || p1.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rexec_tie: ready0/1=%b%b want 10", p0.req_ready, p1.req_ready);
        end
        tick();
        p0.req_valid = 1'b0;
        p1.req_valid = 1'b0;
        tick();
        n_chk++;
        if (p0.rsp_valid !== 1'b1 || p0.rsp_result !== 16'h0007) begin
            n_fail++;
            $display("FAIL rexec_after: v0=%b r=%h want 1 0007", p0.rsp_valid, p0.rsp_result);
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [12];
        bit          pend [2];
        logic [3:0]  rop [2];
        logic [15:0] ra [2];
        logic [15:0] rb [2];
        logic        rdy [2];
        logic        rv [2];
        logic        rr [2];
        logic [17:0] obs [2];
        logic [17:0] exp_v;
        bit          outst;
        bit          ev;
        int          ep, acc, win, last;
        ops = '{4'd0, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd1, 4'd2, 4'd3, 4'd5, 4'd12};
        pend = '{1'b0, 1'b0};
        outst = 1'b0; ep = 0; acc = 0; last = 1; exp_v = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    rop[i]  = ops[$urandom_range(0, 11)];
                    ra[i]   = 16'($urandom);
                    rb[i]   = ($urandom_range(0, 3) == 0) ? ra[i] : 16'($urandom);
                end else if (pend[i] && $urandom_range(0, 9) == 0) begin
                    pend[i] = 1'b0;
                end
                rr[i] = 1'($urandom_range(0, 1));
            end
            p0.req_valid = pend[0]; p0.req_op = rop[0]; p0.req_a = ra[0]; p0.req_b = rb[0];
            p1.req_valid = pend[1]; p1.req_op = rop[1]; p1.req_a = ra[1]; p1.req_b = rb[1];
            p0.rsp_ready = rr[0];
            p1.rsp_ready = rr[1];
            #1;
            rdy[0] = p0.req_ready; rdy[1] = p1.req_ready;
            rv[0]  = p0.rsp_valid; rv[1]  = p1.rsp_valid;
            obs[0] = {p0.rsp_zero, p0.rsp_pos, p0.rsp_result};
            obs[1] = {p1.rsp_zero, p1.rsp_pos, p1.rsp_result};
            win = -1;
            if (!outst) begin
                if (pend[0] && pend[1]) win = 1 - last;
                else if (pend[0])      win = 0;
                else if (pend[1])      win = 1;
            end
            for (int i = 0; i < 2; i++) begin
                n_chk++;
                if (rdy[i] !== 1'(win == i)) begin
                    n_fail++;
                    $display("FAIL rnd_ready%0d: cyc=%0d got %b want %b", i, c, rdy[i], win == i);
                end
                ev = outst && (ep == i) && (c >= acc + 2);
                n_chk++;
                if (rv[i] !== ev) begin
                    n_fail++;
                    $display("FAIL rnd_rsp_valid%0d: cyc=%0d got %b want %b", i, c, rv[i], ev);
                end
                if (ev && rv[i] === 1'b1) begin
                    n_chk++;
                    if (obs[i] !== exp_v) begin
                        n_fail++;
                        $display("FAIL rnd_payload%0d: cyc=%0d got %h want %h", i, c, obs[i],
                                 exp_v);
                    end
                end
            end
            if (outst && c >= acc + 2 && rr[ep]) outst = 1'b0;
            if (win >= 0) begin
                outst = 1'b1;
                ep    = win;
                acc   = c;
                last  = win;
                exp_v = alu_ref(rop[win], ra[win], rb[win]);
                pend[win] = 1'b0;
            end
        end
        tick();
        p0.req_valid = 1'b0; p1.req_valid = 1'b0;
        p0.rsp_ready = 1'b1; p1.rsp_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        p0.req_valid = 1'b0; p0.req_op = '0; p0.req_a = '0; p0.req_b = '0; p0.rsp_ready = 1'b1;
        p1.req_valid = 1'b0; p1.req_op = '0; p1.req_a = '0; p1.req_b = '0; p1.rsp_ready = 1'b1;
        q0.req_valid = 1'b0; q0.req_op = '0; q0.req_a = '0; q0.req_b = '0; q0.rsp_ready = 1'b1;
        q1.req_valid = 1'b0; q1.req_op = '0; q1.req_a = '0; q1.req_b = '0; q1.rsp_ready = 1'b1;
        b_alu_out = '0; b_alu_zero = 1'b0; b_alu_pos = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_alternate();
        test_backpressure();
        test_latency4();
        test_reset_exec();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
